dmem_responder: RTL and testbench

- Responder end of the MEM-stage data-memory interface.
- The MEM stage initiates a request using Size/R_W/E/SE, an address and store data. This block accepts the request, waits a configurable number of cycles, then performs a big-endian byte/halfword/word access on its internal array and returns a one-cycle ready pulse.
- While a request is outstanding it drives a stall indication toward the hazard unit.

---
 rtl/dmem_responder_if.sv | 26 ++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/dmem_responder_if.sv
// Data-memory request/response bundle between the MEM stage (master)
// and the data-memory responder (slave).
interface dmem_responder_if #(
  parameter int ADDR_W = 9
);
  logic              E;
  logic              R_W;
  logic [1:0]        Size;
  logic              SE;
  logic [ADDR_W-1:0] A;
  logic [31:0]       DI;
  logic [31:0]       DO;
  logic              ready;
  logic              err;
  logic              stall;

  modport master (
    output E, R_W, Size, SE, A, DI,
    input  DO, ready, err, stall
  );

  modport slave (
    input  E, R_W, Size, SE, A, DI,
    output DO, ready, err, stall
  );
endinterface

// File: rtl/dmem_responder.sv
// Responder end of the MEM-stage data-memory interface.
// Accepts one request, waits LATENCY cycles, then performs a big-endian
// byte/halfword/word access and pulses ready for one cycle.
// Optional feature macro: DMEM_FAST_READ_EN -- when defined, error-free
// reads skip the wait and respond one cycle after acceptance.
module dmem_responder #(
  parameter int ADDR_W  = 9,
  parameter int LATENCY = 2
) (
  input  logic            clk,
  input  logic            reset,
  dmem_responder_if.slave bus
);
  localparam int DEPTH = 2 ** ADDR_W;

  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

  state_t            state_reg;
  logic [3:0]        cnt_reg;
  logic [ADDR_W-1:0] a_reg;
  logic [31:0]       di_reg;
  logic [1:0]        size_reg;
  logic              rw_reg;
  logic              se_reg;
  logic [31:0]       do_reg;
  logic              ready_reg;
  logic              err_reg;

  logic [7:0] mem [0:DEPTH-1];

  // In IDLE the live bus fields are used so a zero-wait response can be
  // resolved on the accepting edge; afterwards only latched values count.
  logic              in_idle;
  logic [ADDR_W-1:0] req_a;
  logic [31:0]       req_di;
  logic [1:0]        req_size;
  logic              req_rw;
  logic              req_se;
  logic              req_err;
  logic              fast_read;
  logic              resolve;
  logic              do_write;
  logic [ADDR_W-1:0] a1, a2, a3;
  logic [7:0]        b0, b1, b2, b3;
  logic [31:0]       rd_data;

  assign in_idle  = (state_reg == IDLE);
  assign req_a    = in_idle ? bus.A    : a_reg;
  assign req_di   = in_idle ? bus.DI   : di_reg;
  assign req_size = in_idle ? bus.Size : size_reg;
  assign req_rw   = in_idle ? bus.R_W  : rw_reg;
  assign req_se   = in_idle ? bus.SE   : se_reg;

  assign req_err = (req_size == 2'b11)
                 | ((req_size == 2'b01) & req_a[0])
                 | ((req_size == 2'b10) & (req_a[1:0] != 2'b00));

`ifdef DMEM_FAST_READ_EN
  assign fast_read = ~req_rw & ~req_err;
`else
  assign fast_read = 1'b0;
`endif

  // resolve marks the edge that enters RESP: array write and DO capture
  // happen here so the data is already valid during the ready cycle.
  assign resolve  = (in_idle & bus.E & ((LATENCY == 0) | fast_read))
                  | ((state_reg == WAIT) & (cnt_reg == 4'd1));
  assign do_write = resolve & req_rw & ~req_err;

  assign a1 = req_a + ADDR_W'(1);
  assign a2 = req_a + ADDR_W'(2);
  assign a3 = req_a + ADDR_W'(3);
  assign b0 = mem[req_a];
  assign b1 = mem[a1];
  assign b2 = mem[a2];
  assign b3 = mem[a3];

  // Big-endian read formatting with optional sign extension.
  always_comb begin
    rd_data = 32'h0;
    case (req_size)
      2'b00:   rd_data = {{24{req_se & b0[7]}}, b0};
      2'b01:   rd_data = {{16{req_se & b0[7]}}, b0, b1};
      2'b10:   rd_data = {b0, b1, b2, b3};
      default: rd_data = 32'h0;
    endcase
  end

  // Byte array write; only the addressed bytes change, reset aborts it.
  always_ff @(posedge clk) begin
    if (do_write && !reset) begin
      case (req_size)
        2'b00: mem[req_a] <= req_di[7:0];
        2'b01: begin
          mem[req_a] <= req_di[15:8];
          mem[a1]    <= req_di[7:0];
        end
        2'b10: begin
          mem[req_a] <= req_di[31:24];
          mem[a1]    <= req_di[23:16];
          mem[a2]    <= req_di[15:8];
          mem[a3]    <= req_di[7:0];
        end
        default: ;
      endcase
    end
  end

  // Request FSM with registered ready/err/DO outputs.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg <= IDLE;
      cnt_reg   <= 4'd0;
      a_reg     <= '0;
      di_reg    <= 32'h0;
      size_reg  <= 2'b00;
      rw_reg    <= 1'b0;
      se_reg    <= 1'b0;
      do_reg    <= 32'h0;
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
    end else begin
      ready_reg <= 1'b0;
      err_reg   <= 1'b0;
      if (resolve) begin
        ready_reg <= 1'b1;
        err_reg   <= req_err;
        if (!req_rw) do_reg <= req_err ? 32'h0 : rd_data;
      end
      case (state_reg)
        IDLE: begin
          if (bus.E) begin
            a_reg     <= bus.A;
            di_reg    <= bus.DI;
            size_reg  <= bus.Size;
            rw_reg    <= bus.R_W;
            se_reg    <= bus.SE;
            cnt_reg   <= 4'(LATENCY);
            state_reg <= resolve ? RESP : WAIT;
          end
        end
        WAIT: begin
          cnt_reg <= cnt_reg - 4'd1;
          if (cnt_reg == 4'd1) state_reg <= RESP;
        end
        RESP:    state_reg <= IDLE;
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign bus.DO    = do_reg;
  assign bus.ready = ready_reg;
  assign bus.err   = err_reg;
  assign bus.stall = (in_idle & bus.E) | (state_reg == WAIT);

endmodule

// File: tb/tb_dmem_responder.sv
// Scoreboard bench for dmem_responder: the driver pushes hand-computed
// responses (data, err, ready cycle); a negedge monitor pops and compares.
module tb_dmem_responder;
  localparam int ADDR_W  = 9;
  localparam int LATENCY = 2;
`ifdef DMEM_FAST_READ_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif

  logic clk;
  logic reset;
  int   cyc;
  int   checks;
  int   errors;

  typedef struct {
    string       name;
    logic [31:0] d;
    logic        e;
    int          cyc;
  } exp_t;

  exp_t q[$];
  exp_t mon_x;

  dmem_responder_if #(.ADDR_W(ADDR_W)) bus ();

  dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s got=%08h expected=%08h (cyc %0d)", nm, act, expv, cyc);
    end
  endtask

  // Monitor: every ready pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && bus.ready === 1'b1) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ready got=1 expected=0 (cyc %0d)", cyc);
      end else begin
        mon_x = q.pop_front();
        check({mon_x.name, "_do"},  bus.DO, mon_x.d);
        check({mon_x.name, "_err"}, {31'h0, bus.err}, {31'h0, mon_x.e});
        check({mon_x.name, "_cyc"}, cyc, mon_x.cyc);
        $display("resp %-10s DO=%08h err=%0b cyc=%0d", mon_x.name, bus.DO, bus.err, cyc);
      end
    end
  end

  // Issue one request. b2b: previous request left E high and we are in its
  // ready cycle. keep: leave E high after this response.
  task automatic req(input string nm, input logic rw, input logic [1:0] sz,
                     input logic se_i, input logic [ADDR_W-1:0] a,
                     input logic [31:0] di, input logic [31:0] exp_d,
                     input logic exp_e, input bit b2b, input bit keep);
    exp_t x;
    int   lat;
    bit   got;
    lat = (FAST && !rw && !exp_e) ? 0 : LATENCY;
    if (!b2b) @(negedge clk);
    bus.E    = 1'b1;
    bus.R_W  = rw;
    bus.Size = sz;
    bus.SE   = se_i;
    bus.A    = a;
    bus.DI   = di;
    x.name = nm;
    x.d    = exp_d;
    x.e    = exp_e;
    x.cyc  = cyc + (b2b ? 2 : 1) + lat;
    q.push_back(x);
    if (!b2b) begin
      #1;
      check({nm, "_stall_req"}, {31'h0, bus.stall}, 32'h1);
    end
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.ready === 1'b1) begin
        got = 1'b1;
        check({nm, "_stall_rdy"}, {31'h0, bus.stall}, 32'h0);
        break;
      end else begin
        check({nm, "_stall_wait"}, {31'h0, bus.stall}, 32'h1);
      end
    end
    if (!got) begin
      checks++;
      errors++;
      $display("FAIL %s_timeout got=no_ready expected=ready", nm);
    end
    if (!keep) bus.E = 1'b0;
  endtask

  initial begin
    cyc      = 0;
    checks   = 0;
    errors   = 0;
    reset    = 1'b1;
    bus.E    = 1'b0;
    bus.R_W  = 1'b0;
    bus.Size = 2'b00;
    bus.SE   = 1'b0;
    bus.A    = '0;
    bus.DI   = 32'h0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("rst_do",    bus.DO, 32'h0);
    check("rst_ready", {31'h0, bus.ready}, 32'h0);
    check("rst_err",   {31'h0, bus.err},   32'h0);
    check("rst_stall", {31'h0, bus.stall}, 32'h0);

    //   name         rw  sz     se  A      DI            exp DO        err b2b keep
    req("w_word4",    1, 2'b10, 0, 9'd4,  32'hDEADBEEF, 32'h00000000, 0, 0, 0);
    req("r_word4",    0, 2'b10, 0, 9'd4,  32'h0,        32'hDEADBEEF, 0, 0, 0);
    req("r_b5_se",    0, 2'b00, 1, 9'd5,  32'h0,        32'hFFFFFFAD, 0, 0, 0);
    req("r_b5_ze",    0, 2'b00, 0, 9'd5,  32'h0,        32'h000000AD, 0, 0, 0);
    req("r_h6_se",    0, 2'b01, 1, 9'd6,  32'h0,        32'hFFFFBEEF, 0, 0, 0);
    req("w_b7",       1, 2'b00, 0, 9'd7,  32'hFFFFFF12, 32'hFFFFBEEF, 0, 0, 1);
    req("r_word4_bb", 0, 2'b10, 1, 9'd4,  32'h0,        32'hDEADBE12, 0, 1, 0);
    req("w_mis6",     1, 2'b10, 0, 9'd6,  32'h55667788, 32'hDEADBE12, 1, 0, 0);
    req("r_word4_b",  0, 2'b10, 0, 9'd4,  32'h0,        32'hDEADBE12, 0, 0, 0);
    req("r_mis_h3",   0, 2'b01, 0, 9'd3,  32'h0,        32'h00000000, 1, 0, 0);
    req("r_sz11",     0, 2'b11, 0, 9'd0,  32'h0,        32'h00000000, 1, 0, 0);
    req("w_word8",    1, 2'b10, 0, 9'd8,  32'hCAFEF00D, 32'h00000000, 0, 0, 0);

    // Write aborted by reset during WAIT: no write, no ready pulse.
    @(negedge clk);
    bus.E    = 1'b1;
    bus.R_W  = 1'b1;
    bus.Size = 2'b10;
    bus.A    = 9'd8;
    bus.DI   = 32'h11223344;
    @(negedge clk);
    check("abort_stall_wait", {31'h0, bus.stall}, 32'h1);
    reset = 1'b1;
    bus.E = 1'b0;
    @(negedge clk);
    check("abort_ready", {31'h0, bus.ready}, 32'h0);
    check("abort_do",    bus.DO, 32'h0);
    check("abort_err",   {31'h0, bus.err},   32'h0);
    check("abort_stall", {31'h0, bus.stall}, 32'h0);
    reset = 1'b0;
    repeat (6) @(negedge clk);
    $display("abort write A=8 under reset done");

    req("r_word8",    0, 2'b10, 0, 9'd8,  32'h0,        32'hCAFEF00D, 0, 0, 0);
    req("w_h10",      1, 2'b01, 0, 9'd10, 32'hFFFFA5B6, 32'hCAFEF00D, 0, 0, 0);
    req("r_word8_b",  0, 2'b10, 0, 9'd8,  32'h0,        32'hCAFEA5B6, 0, 0, 0);

    repeat (5) @(negedge clk);
    check("queue_empty", q.size(), 32'h0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
